// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer
//   Instruction buffer and issue gate between fetch and decode/execute.
//   Fetched packets are queued in a DEPTH-entry circular FIFO. The head
//   packet is offered to decode and is held back only while one of its
//   source or destination registers is still owed a result by an in-flight
//   multi-cycle operation. Those operations are tracked in a 32-bit
//   register scoreboard.
//
//   Optional feature: define DECODE_BYPASS_EN to let a packet arriving at an
//   empty buffer be issued in the same cycle (0-cycle fetch-to-issue path).
//   If the macro is undefined, no combinational f_* -> d_* path exists.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   f_valid/f_ready               fetch handshake (f_ready registered)
//   f_pc/f_instr/f_exc/
//   f_ecause/f_etval              incoming packet fields
//   flush                         discard all buffered packets
//   d_valid/d_ready               issue handshake for the head packet
//   d_pc/d_instr/d_exc/
//   d_ecause/d_etval              head packet fields
//   hz_rden1/2, hz_raddr1/2       head source register usage
//   hz_wren, hz_waddr, hz_long    head destination usage, multi-cycle flag
//   cmp_valid, cmp_waddr          multi-cycle operation completion
//   busy                          scoreboard, bit n = xn result pending
//   count                         occupied FIFO entries
module decode_issue_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int ECW   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [XLEN-1:0]            f_pc,
  input  logic [31:0]                f_instr,
  input  logic                       f_exc,
  input  logic [ECW-1:0]             f_ecause,
  input  logic [XLEN-1:0]            f_etval,
  input  logic                       flush,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [XLEN-1:0]            d_pc,
  output logic [31:0]                d_instr,
  output logic                       d_exc,
  output logic [ECW-1:0]             d_ecause,
  output logic [XLEN-1:0]            d_etval,
  input  logic                       hz_rden1,
  input  logic                       hz_rden2,
  input  logic [4:0]                 hz_raddr1,
  input  logic [4:0]                 hz_raddr2,
  input  logic                       hz_wren,
  input  logic [4:0]                 hz_waddr,
  input  logic                       hz_long,
  input  logic                       cmp_valid,
  input  logic [4:0]                 cmp_waddr,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [31:0]     instr_mem  [DEPTH];
  logic            exc_mem    [DEPTH];
  logic [ECW-1:0]  ecause_mem [DEPTH];
  logic [XLEN-1:0] etval_mem  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next;
  logic          f_ready_r;
  logic [31:0]   busy_r;
  logic [31:0]   busy_next;

  logic empty;
  logic bypass;
  logic hazard;
  logic push;
  logic pop;
  logic fifo_push;
  logic fifo_pop;
  logic issue_set;

  assign empty   = (count_r == '0);
  assign f_ready = f_ready_r;
  assign busy    = busy_r;
  assign count   = count_r;

`ifdef DECODE_BYPASS_EN
  // An empty buffer forwards the incoming packet straight to decode.
  assign bypass   = empty & f_valid & ~flush;
  assign d_pc     = bypass ? f_pc     : pc_mem[head];
  assign d_instr  = bypass ? f_instr  : instr_mem[head];
  assign d_exc    = bypass ? f_exc    : exc_mem[head];
  assign d_ecause = bypass ? f_ecause : ecause_mem[head];
  assign d_etval  = bypass ? f_etval  : etval_mem[head];
`else
  assign bypass   = 1'b0;
  assign d_pc     = pc_mem[head];
  assign d_instr  = instr_mem[head];
  assign d_exc    = exc_mem[head];
  assign d_ecause = ecause_mem[head];
  assign d_etval  = etval_mem[head];
`endif

  assign hazard = (hz_rden1 & busy_r[hz_raddr1]) |
                  (hz_rden2 & busy_r[hz_raddr2]) |
                  (hz_wren  & busy_r[hz_waddr]);

  // Exception packets never execute, so register hazards cannot hold them.
  assign d_valid = (~empty | bypass) & ~flush & (d_exc | ~hazard);

  assign push = f_valid & f_ready_r & ~flush;
  assign pop  = d_valid & d_ready;

  // A bypassed packet that issues immediately never occupies a FIFO slot;
  // while bypassing, the FIFO is empty so nothing is popped from it.
  assign fifo_push = push & ~(bypass & pop);
  assign fifo_pop  = pop & ~bypass;

  assign issue_set = pop & hz_long & hz_wren & (hz_waddr != 5'd0);

  always_comb begin
    count_next = count_r;
    if (fifo_push && !fifo_pop) begin
      count_next = count_r + CW'(1);
    end else if (fifo_pop && !fifo_push) begin
      count_next = count_r - CW'(1);
    end
  end

  // Completion clears first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_next = busy_r;
    if (cmp_valid) begin
      busy_next[cmp_waddr] = 1'b0;
    end
    if (issue_set) begin
      busy_next[hz_waddr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Flush empties the FIFO but keeps the scoreboard: long operations that
  // already issued will still write back and must keep dependents stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count_r   <= '0;
      f_ready_r <= 1'b1;
      busy_r    <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count_r   <= '0;
      f_ready_r <= 1'b1;
      busy_r    <= busy_next;
    end else begin
      if (fifo_push) begin
        tail <= tail + PW'(1);
      end
      if (fifo_pop) begin
        head <= head + PW'(1);
      end
      count_r   <= count_next;
      f_ready_r <= (count_next < DEPTH_C);
      busy_r    <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[tail]     <= f_pc;
      instr_mem[tail]  <= f_instr;
      exc_mem[tail]    <= f_exc;
      ecause_mem[tail] <= f_ecause;
      etval_mem[tail]  <= f_etval;
    end
  end

endmodule

// File: doc/decode_issue_buffer.md
# decode_issue_buffer

Parametrised instruction buffer and issue gate between the fetch stage and the decode/execute pipeline. It holds up to DEPTH fetched instruction packets in a FIFO. It presents the head packet to the decode logic and tracks destination registers of in-flight multi-cycle operations (division, multi-cycle bit-manipulation) in a register scoreboard. A single hazard stall therefore only holds the dependent instruction, not every instruction behind a long operation.

## Interface
Parameters:
- XLEN, 32, data/address width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- ECW, 4, exception cause width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- f_valid  in  1  fetch packet valid
- f_ready  out  1  buffer can accept; registered, = (count < DEPTH)
- f_pc  in  XLEN  packet PC
- f_instr  in  32  packet instruction
- f_exc  in  1  fetch exception flag
- f_ecause  in  ECW  fetch exception cause
- f_etval  in  XLEN  fetch exception value
- flush  in  1  pipeline clear (jump, exception, mret)
- d_valid  out  1  head packet issuable
- d_ready  in  1  downstream accepts head
- d_pc, d_instr, d_exc, d_ecause, d_etval  out  XLEN/32/1/ECW/XLEN  head packet fields
- hz_rden1, hz_rden2  in  1  head reads rs1/rs2 (from external decoder driven by d_instr)
- hz_raddr1, hz_raddr2  in  5  head source registers
- hz_wren  in  1  head writes rd
- hz_waddr  in  5  head destination
- hz_long  in  1  head is a multi-cycle writer
- cmp_valid  in  1  multi-cycle op completes this cycle
- cmp_waddr  in  5  its destination
- busy  out  32  scoreboard, bit n = xn pending; bit 0 constant 0
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- FIFO: circular storage, head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count tracked separately (full = count==DEPTH, empty = count==0).
- Push = f_valid & f_ready & ~flush. Pop (issue) = d_valid & d_ready.
- Hazard = (hz_rden1 & busy[hz_raddr1]) | (hz_rden2 & busy[hz_raddr2]) | (hz_wren & busy[hz_waddr]).
- d_valid = ~empty & ~hazard & ~flush. d_* fields always show head entry, undefined when empty.
- Exception packets (d_exc=1) bypass the hazard check: d_valid = ~empty & ~flush.
- Scoreboard set on issue when hz_long & hz_wren & hz_waddr≠0. Scoreboard cleared on cmp_valid for cmp_waddr. Same register set and cleared in the same cycle: set wins.
- Flush: head=tail=0, count=0 next cycle. Same-cycle push is dropped. Scoreboard is NOT cleared, because in-flight long ops still complete.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full is impossible (f_ready=0).

## Timing
- Reset (rst=0 at clk edge): count=0, pointers=0, busy=0, f_ready=1, d_valid=0. Reset mid-operation discards all entries and scoreboard state.
- Latency without bypass: packet pushed in cycle n is visible on d_* with d_valid in cycle n+1.
- f_ready depends only on registered count (no d_ready→f_ready comb path).
- d_valid is combinational from registered head state, hz_* and flush.
- Scoreboard update visible on busy the cycle after issue/completion. A completion in cycle n unblocks a dependent head in cycle n+1.

## Configuration
- DECODE_BYPASS_EN defined: when count==0, f_valid=1 and no flush, the incoming packet drives d_* combinationally with d_valid subject to hazard. If it is issued the same cycle it is not written to the FIFO (0-cycle latency). Otherwise it is pushed normally.
- Undefined: no bypass; minimum fetch-to-issue latency 1 cycle; no f_*→d_* combinational path.

## Test plan
- Reset, then push 4 packets PC 0x0,0x4,0x8,0xC with d_ready=0 → count=4, f_ready=0. Release d_ready → issue in order over 4 cycles, count 4→0.
- Long op writes x5 (hz_long=1, hz_waddr=5) issues. Next head reads x5 → d_valid=0, busy[5]=1. cmp_valid with cmp_waddr=5 → d_valid=1 next cycle.
- Issue long op to x0 → busy stays 0. Issue long to x7 while cmp_waddr=7 same cycle → busy[7]=1.
- count=3, assert flush with f_valid=1 → next cycle count=0, d_valid=0, busy unchanged.
- Wrap: 10 push/pop pairs, DEPTH=4 → PCs issued in order, no loss or duplicate. With DECODE_BYPASS_EN, empty FIFO and d_ready=1 → same-cycle issue, count stays 0.
- Exception packet (f_exc=1, ecause=1) whose hz_raddr1 is busy → d_valid=1, d_exc=1.
